// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the SPARC load/store path to ram128x32:
// op3 encodings, trap codes, access sizes and the controller state enum.
package mem_pkg;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;

    localparam logic [1:0] TRAP_OK       = 2'b00;
    localparam logic [1:0] TRAP_MISALIGN = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT  = 2'b10;
    localparam logic [1:0] TRAP_ILLEGAL  = 2'b11;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RELEASE,
        ST_RESP
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response bus from the load/store unit plus the RAM-side lines.
// slave = the controller's view, master = the datapath/RAM environment.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_op3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_trap;
    logic              mem_enable;
    logic [5:0]        mem_opcode;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_mfc;

    modport slave (
        input  req_valid, req_op3, req_addr, req_wdata, mem_rdata, mem_mfc,
        output req_ready, rsp_valid, rsp_rdata, rsp_trap,
               mem_enable, mem_opcode, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_op3, req_addr, req_wdata, mem_rdata, mem_mfc,
        input  req_ready, rsp_valid, rsp_rdata, rsp_trap,
               mem_enable, mem_opcode, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl_decode.sv
// Combinational op3/address classifier, shared with the datapath trap logic.
module mem_op_decode
    import mem_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic [5:0]        op3_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              legal_o,
    output logic              is_store_o,
    output logic [1:0]        size_o,
    output logic              aligned_o
);

    always_comb begin
        legal_o    = 1'b0;
        is_store_o = 1'b0;
        size_o     = SZ_WORD;
        case (op3_i)
            OP_LD:   begin legal_o = 1'b1; size_o = SZ_WORD; end
            OP_LDUB: begin legal_o = 1'b1; size_o = SZ_BYTE; end
            OP_LDUH: begin legal_o = 1'b1; size_o = SZ_HALF; end
            OP_LDSB: begin legal_o = 1'b1; size_o = SZ_BYTE; end
            OP_LDSH: begin legal_o = 1'b1; size_o = SZ_HALF; end
            OP_ST:   begin legal_o = 1'b1; size_o = SZ_WORD; is_store_o = 1'b1; end
            OP_STB:  begin legal_o = 1'b1; size_o = SZ_BYTE; is_store_o = 1'b1; end
            OP_STH:  begin legal_o = 1'b1; size_o = SZ_HALF; is_store_o = 1'b1; end
            default: begin legal_o = 1'b0; size_o = SZ_WORD; end
        endcase
    end

    always_comb begin
        aligned_o = 1'b1;
        case (size_o)
            SZ_HALF: aligned_o = ~addr_i[0];
            SZ_WORD: aligned_o = (addr_i[1:0] == 2'b00);
            default: aligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller owning MAR/MDR; runs the RAM
// enable/MFC handshake and reports load data or a trap code.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic          clk_i,
    input logic          reset_i,
    mem_access_ctrl_if.slave bus
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [ADDR_W-1:0]   mar_q,   mar_d;
    logic [DATA_W-1:0]   mdr_q,   mdr_d;
    logic [5:0]          op_q,    op_d;
    logic [1:0]          trap_q,  trap_d;
    logic                load_q,  load_d;

    logic                dec_legal;
    logic                dec_store;
    logic [1:0]          dec_size;
    logic                dec_aligned;
    logic                unused_dec_size;

    mem_op_decode #(.ADDR_W(ADDR_W)) u_decode (
        .op3_i      (bus.req_op3),
        .addr_i     (bus.req_addr),
        .legal_o    (dec_legal),
        .is_store_o (dec_store),
        .size_o     (dec_size),
        .aligned_o  (dec_aligned)
    );

    // Size is folded into the aligned flag already; the controller needs no more.
    assign unused_dec_size = ^dec_size;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            op_q    <= '0;
            trap_q  <= TRAP_OK;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            op_q    <= op_d;
            trap_q  <= trap_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        op_d    = op_q;
        trap_d  = trap_q;
        load_d  = load_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    mar_d  = bus.req_addr;
                    mdr_d  = bus.req_wdata;
                    op_d   = bus.req_op3;
                    load_d = dec_legal & ~dec_store;
                    cnt_d  = '0;
                    trap_d = TRAP_OK;
                    // Bad requests go straight to the response so the RAM never sees them.
                    if (!dec_legal) begin
                        trap_d  = TRAP_ILLEGAL;
                        state_d = ST_RESP;
                    end else if (!dec_aligned) begin
                        trap_d  = TRAP_MISALIGN;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end

            ST_ACCESS: begin
                // MFC is checked before expiry so a completion on the last edge still wins.
                if (bus.mem_mfc) begin
                    if (load_q) mdr_d = bus.mem_rdata;
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    trap_d  = TRAP_TIMEOUT;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (!bus.mem_mfc) begin
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    trap_d  = TRAP_TIMEOUT;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.rsp_trap   = (state_q == ST_RESP) ? trap_q : TRAP_OK;
    assign bus.rsp_rdata  = ((state_q == ST_RESP) && (trap_q == TRAP_OK) && load_q) ? mdr_q : '0;
    assign bus.mem_enable = (state_q == ST_ACCESS);
    assign bus.mem_opcode = op_q;
    assign bus.mem_addr   = mar_q;
    assign bus.mem_wdata  = mdr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a word-granular RAM stub with programmable MFC
// delay/hold, a table of directed vectors, a reset corner and random traffic.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 1) ? 32'hFFFF_FFE8 : (32'hC0DE_0000 | 32'(i));
    endfunction

    // ---------------- RAM stub (lane handling belongs to the real RAM) -------
    logic [31:0] ram [32];
    bit          ram_init = 1'b0;
    int          mfc_delay = 0;
    int          mfc_hold  = 0;
    int          wait_cnt  = 0;
    int          hold_cnt  = 0;
    int          en_count  = 0;
    int          cap_count = 0;
    logic [5:0]  cap_op;
    logic [6:0]  cap_addr;
    logic [31:0] cap_wdata;

    always @(negedge clk) begin
        if (reset) begin
            bus.mem_mfc   = 1'b0;
            bus.mem_rdata = '0;
            wait_cnt      = 0;
            if (!ram_init) begin
                for (int i = 0; i < 32; i++) ram[i] = init_word(i);
                ram_init = 1'b1;
            end
        end else if (bus.mem_enable) begin
            en_count++;
            if (!bus.mem_mfc) begin
                if (wait_cnt >= mfc_delay) begin
                    bus.mem_mfc = 1'b1;
                    hold_cnt    = 0;
                    cap_count++;
                    cap_op    = bus.mem_opcode;
                    cap_addr  = bus.mem_addr;
                    cap_wdata = bus.mem_wdata;
                    if (bus.mem_opcode[2]) ram[bus.mem_addr[6:2]] = bus.mem_wdata;
                    else                   bus.mem_rdata = ram[bus.mem_addr[6:2]];
                end else begin
                    wait_cnt++;
                end
            end
        end else begin
            wait_cnt = 0;
            if (bus.mem_mfc) begin
                if (hold_cnt >= mfc_hold) bus.mem_mfc = 1'b0;
                else                      hold_cnt++;
            end
        end
    end

    // ---------------- reference model ---------------------------------------
    logic [31:0] ref_mem [32];

    // Outcome of one request from the protocol rules: trap, latency from the
    // accept edge to the edge ending the response pulse, and RAM involvement.
    task automatic predict(input logic [5:0] op, input logic [6:0] addr, input int d, input int h,
                           output logic [1:0] trap, output int lat, output bit en,
                           output bit reach, output bit st);
        bit legal;
        int sz;
        legal = 1'b1; st = 1'b0; sz = 1;
        case (op)
            OP_LD:            sz = 4;
            OP_LDUB, OP_LDSB: sz = 1;
            OP_LDUH, OP_LDSH: sz = 2;
            OP_ST:   begin sz = 4; st = 1'b1; end
            OP_STB:  begin sz = 1; st = 1'b1; end
            OP_STH:  begin sz = 2; st = 1'b1; end
            default: legal = 1'b0;
        endcase
        en = 1'b0; reach = 1'b0;
        if (!legal)                        begin trap = 2'b11; lat = 1; end
        else if ((int'(addr) % sz) != 0)   begin trap = 2'b01; lat = 1; end
        else if (d >= TIMEOUT)             begin trap = 2'b10; lat = TIMEOUT + 1; en = 1'b1; end
        else if (h >= TIMEOUT)             begin trap = 2'b10; lat = d + TIMEOUT + 2; en = 1'b1; reach = 1'b1; end
        else                               begin trap = 2'b00; lat = d + h + 3; en = 1'b1; reach = 1'b1; end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((!bus.req_ready || bus.mem_mfc) && n < 100) begin
            step();
            n++;
        end
        chk("idle_wait", {31'b0, bus.req_ready & ~bus.mem_mfc}, 32'd1);
    endtask

    task automatic run_req(input string nm, input logic [5:0] op, input logic [6:0] addr,
                           input logic [31:0] wd, input int d, input int h,
                           input logic [1:0] etrap, input logic [31:0] erd, input int elat);
        int          en0, cap0, lat, plat;
        bit          got, ready_low, en_exp, reach, st;
        logic [1:0]  trap, ptrap;
        logic [31:0] rd;
        wait_idle();
        mfc_delay = d;
        mfc_hold  = h;
        en0  = en_count;
        cap0 = cap_count;
        bus.req_valid = 1'b1;
        bus.req_op3   = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op3   = 6'($urandom);
        bus.req_addr  = 7'($urandom);
        bus.req_wdata = $urandom;
        got = 1'b0; ready_low = 1'b1; lat = 0; trap = 2'b00; rd = '0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (bus.rsp_valid) begin
                got  = 1'b1;
                lat  = k + 1;
                trap = bus.rsp_trap;
                rd   = bus.rsp_rdata;
                break;
            end
            if (bus.req_ready) ready_low = 1'b0;
        end
        chk({nm, "_rsp_seen"}, {31'b0, got}, 32'd1);
        chk({nm, "_trap"}, {30'b0, trap}, {30'b0, etrap});
        chk({nm, "_rdata"}, rd, erd);
        chk({nm, "_latency"}, 32'(lat), 32'(elat));
        chk({nm, "_busy_ready_low"}, {31'b0, ready_low}, 32'd1);
        step();
        chk({nm, "_pulse_end"}, {29'b0, bus.rsp_valid, bus.mem_enable, bus.req_ready}, 32'b001);
        predict(op, addr, d, h, ptrap, plat, en_exp, reach, st);
        chk({nm, "_enable_seen"}, {31'b0, en_count != en0}, {31'b0, en_exp});
        if (reach) begin
            chk({nm, "_ram_op"}, {26'b0, cap_op}, {26'b0, op});
            chk({nm, "_ram_addr"}, {25'b0, cap_addr}, {25'b0, addr});
            chk({nm, "_ram_access"}, 32'(cap_count - cap0), 32'd1);
            if (st) begin
                chk({nm, "_ram_wdata"}, cap_wdata, wd);
                ref_mem[addr[6:2]] = wd;
            end
        end
    endtask

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [6:0]  addr;
        logic [31:0] wd;
        int          d;
        int          h;
        logic [1:0]  trap;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vt [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rsp_seen;
        logic [5:0] ops [10];
        for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
        ops = '{OP_LD, OP_LDUB, OP_LDUH, OP_LDSB, OP_LDSH, OP_ST, OP_STB, OP_STH, 6'b111111, 6'b011000};

        vt[0]  = '{"ld4",       OP_LD,     7'd4,  32'h0,        0, 0,           2'b00, 32'hFFFF_FFE8, 3};
        vt[1]  = '{"st8",       OP_ST,     7'd8,  32'h1234_5678, 0, 0,          2'b00, 32'h0,         3};
        vt[2]  = '{"ld8",       OP_LD,     7'd8,  32'h0,        0, 0,           2'b00, 32'h1234_5678, 3};
        vt[3]  = '{"ldsh3",     OP_LDSH,   7'd3,  32'h0,        0, 0,           2'b01, 32'h0,         1};
        vt[4]  = '{"illegal",   6'b111111, 7'd0,  32'h0,        0, 0,           2'b11, 32'h0,         1};
        vt[5]  = '{"ill_mis",   6'b111111, 7'd3,  32'h0,        0, 0,           2'b11, 32'h0,         1};
        vt[6]  = '{"ld_mis2",   OP_LD,     7'd2,  32'h0,        0, 0,           2'b01, 32'h0,         1};
        vt[7]  = '{"sth_mis",   OP_STH,    7'd9,  32'hDEAD_BEEF, 0, 0,          2'b01, 32'h0,         1};
        vt[8]  = '{"ldub7",     OP_LDUB,   7'd7,  32'h0,        0, 0,           2'b00, 32'hFFFF_FFE8, 3};
        vt[9]  = '{"ldsh6_d2",  OP_LDSH,   7'd6,  32'h0,        2, 1,           2'b00, 32'hFFFF_FFE8, 6};
        vt[10] = '{"mfc_tmo",   OP_LD,     7'd12, 32'h0,        99, 0,          2'b10, 32'h0,         17};
        vt[11] = '{"mfc_expiry",OP_LD,     7'd12, 32'h0,        15, 0,          2'b00, 32'hC0DE_0003, 18};
        vt[12] = '{"rel_stuck", OP_LD,     7'd20, 32'h0,        0, TIMEOUT+2,   2'b10, 32'h0,         18};
        vt[13] = '{"rel_edge",  OP_ST,     7'd16, 32'hA5A5_5A5A, 1, TIMEOUT-1,  2'b00, 32'h0,         19};

        bus.req_valid = 1'b0;
        bus.req_op3   = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("reset_outs", {31'b0, |{bus.mem_enable, bus.rsp_valid, bus.rsp_rdata, bus.rsp_trap,
                                    bus.mem_opcode, bus.mem_addr, bus.mem_wdata}}, 32'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 14; i++)
            run_req(vt[i].name, vt[i].op, vt[i].addr, vt[i].wd, vt[i].d, vt[i].h,
                    vt[i].trap, vt[i].rdata, vt[i].lat);
        run_req("ld16", OP_LD, 7'd16, 32'h0, 0, 0, 2'b00, 32'hA5A5_5A5A, 3);

        // Reset while the controller waits on MFC.
        wait_idle();
        mfc_delay = 99;
        mfc_hold  = 0;
        bus.req_valid = 1'b1;
        bus.req_op3   = OP_LD;
        bus.req_addr  = 7'd0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        step();
        step();
        chk("rst_mid_enable_before", {31'b0, bus.mem_enable}, 32'd1);
        reset = 1'b1;
        rsp_seen = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_enable_drop", {31'b0, bus.mem_enable}, 32'd0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (bus.rsp_valid) rsp_seen = 1'b1;
        end
        chk("rst_mid_no_rsp", {31'b0, rsp_seen}, 32'd0);
        chk("rst_mid_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_mid_outs", {31'b0, |{bus.mem_enable, bus.rsp_valid, bus.rsp_rdata, bus.rsp_trap,
                                      bus.mem_opcode, bus.mem_addr, bus.mem_wdata}}, 32'd0);
        run_req("ldub5", OP_LDUB, 7'd5, 32'h0, 0, 0, 2'b00, 32'hFFFF_FFE8, 3);

        // Random traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [5:0]  op;
            logic [6:0]  addr;
            logic [31:0] wd, erd;
            logic [1:0]  etrap;
            int          d, h, r, elat;
            bit          en, reach, st;
            op   = ops[$urandom_range(0, 9)];
            addr = 7'($urandom_range(0, 127));
            if (($urandom_range(0, 1) == 1) && (op != OP_LDUB)) addr[1:0] = 2'b00;
            wd = $urandom;
            r = $urandom_range(0, 9);
            if (r < 6)       d = $urandom_range(0, 3);
            else if (r == 6) d = TIMEOUT - 1;
            else if (r == 7) d = TIMEOUT + $urandom_range(0, 2);
            else             d = $urandom_range(0, 6);
            r = $urandom_range(0, 9);
            if (r < 8)       h = $urandom_range(0, 2);
            else if (r == 8) h = TIMEOUT - 1;
            else             h = TIMEOUT + 1;
            predict(op, addr, d, h, etrap, elat, en, reach, st);
            erd = (etrap == 2'b00 && !st) ? ref_mem[addr[6:2]] : 32'h0;
            run_req($sformatf("rnd%0d", n), op, addr, wd, d, h, etrap, erd, elat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
